count_seq_monitor: RTL and testbench
====================================

Name: count_seq_monitor

Overview:
Downstream consumer of the 2-bit up-counter output. It samples the counter value on a strobe, checks it follows the 00→01→10→11→00 sequence, and declares lock after a run of correct samples. It then counts full wrap-arounds and flags sequence errors. It sits between the counter and status/debug logic.

Parameters:
LOCK_LEN, 4, consecutive correct samples needed to enter TRACK; legal range 2..15.
WRAP_W, 8, width of the wrap counter.
ERR_W, 4, width of the error counter; always saturates.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-low reset; sampled on posedge clk.
q_in  input  2  counter value under observation.
valid_in  input  1  q_in is sampled on any posedge where valid_in=1.
err_clr  input  1  clears err_sticky and err_count.
locked  output  1  1 while in TRACK.
wrap_pulse  output  1  one-cycle pulse on each tracked 11→00 transition.
wrap_count  output  WRAP_W  number of tracked wraps.
err_pulse  output  1  one-cycle pulse on each mismatch while in TRACK.
err_sticky  output  1  set by err_pulse, held until err_clr or reset.
err_count  output  ERR_W  number of TRACK mismatches, saturating.

Behaviour:
- Reset (reset=0 at posedge): state=IDLE, exp=0, run=0. All outputs are 0.
- All outputs are registered and update 1 cycle after the sampling edge.
- Internal registers: exp[1:0], the expected next value; run[3:0], the current correct-run length. exp arithmetic is mod 4 (11+1=00).
- IDLE: on valid, exp<=q_in+1 and run<=1, then go to ACQUIRE.
- ACQUIRE, valid with q_in==exp: exp<=q_in+1, run<=run+1. When run+1==LOCK_LEN, go to TRACK; locked=1 on the next cycle.
- ACQUIRE, valid with q_in!=exp: reseed with exp<=q_in+1 and run<=1. No error is flagged in ACQUIRE.
- TRACK, valid with q_in==exp: exp<=q_in+1. If q_in==00: wrap_pulse=1 and wrap_count increments.
- TRACK, valid with q_in!=exp:
  - err_pulse=1, err_sticky<=1, err_count increments (saturates at all-ones).
  - Reseed exp<=q_in+1, run<=1, go to ACQUIRE; locked=0 next cycle.
  - No wrap is counted on a mismatching sample, even if q_in==00.
- valid_in=0: all state is held. wrap_pulse and err_pulse are 0.
- err_clr=1 clears err_sticky and err_count to 0. If a new error occurs in the same cycle, the error wins: err_sticky=1, err_count=1.
- err_clr does not affect state, wrap_count, or locked.
- Reset mid-operation returns to IDLE and clears all counters regardless of other inputs.

Optional Feature:
- Macro: COUNT_SEQ_MONITOR_WRAP_SAT_EN.
- Defined: wrap_count saturates at 2^WRAP_W-1; further wraps still pulse wrap_pulse.
- Undefined: wrap_count rolls over to 0 after 2^WRAP_W-1.

Decomposition:
- Package count_seq_monitor_pkg holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_ACQUIRE=2'd1, ST_TRACK=2'd2;
  - the counter sequence constants SEQ_FIRST=2'b00 and SEQ_LAST=2'b11.
- One sub-module, sat_counter (parameter W, inputs inc/clr, output cnt), is used for err_count. With COUNT_SEQ_MONITOR_WRAP_SAT_EN it is also used for wrap_count.

Test Plan:
- Reset, then valid=1 every cycle with the counter free-running from 00, LOCK_LEN=4 → locked=1 one cycle after the 4th sample (11). The next sample 00 gives wrap_pulse=1 and wrap_count=1. After 3 more full cycles, wrap_count=4.
- Locked, then inject sample 10 where 01 is expected → err_pulse=1, err_sticky=1, err_count=1, locked=0. Samples 11,00,01 follow → relock after the 01 sample, with no wrap counted during ACQUIRE.
- 20 forced mismatches while locked, with relock between each → err_count holds at 15 and err_sticky=1. Then err_clr=1 → both 0 next cycle.
- err_clr=1 in the same cycle as a TRACK mismatch → err_sticky=1, err_count=1.
- valid_in toggled 1/0 while the counter steps only on valid cycles → same lock/wrap timing as the first test in valid-cycle units, and no pulses on idle cycles.
- reset=0 asserted while locked with wrap_count=5 → next cycle all outputs 0 and state IDLE. WRAP_W=2 with 5 wraps → wrap_count=3 if the macro is defined, 1 if not.

Source files
------------

// File: rtl/count_seq_monitor_pkg.sv
// Shared state encoding, counter-sequence constants and the mod-4 successor
// helper for the count_seq_monitor slice.
package count_seq_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_TRACK   = 2'd2
   } state_e;

   localparam logic [1:0] SEQ_FIRST = 2'b00;
   localparam logic [1:0] SEQ_LAST  = 2'b11;

   function automatic logic [1:0] next_val(input logic [1:0] q);
      return (q == SEQ_LAST) ? SEQ_FIRST : q + 2'd1;
   endfunction

endpackage

// File: rtl/count_seq_monitor_sat_counter.sv
// Saturating up-counter with clear; a simultaneous increment beats the clear,
// so clr & inc leaves the count at 1.
module sat_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = inc ? W'(1) : '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/count_seq_monitor.sv
// Monitors a 2-bit up-counter: acquires lock, counts tracked wraps, flags errors.
// COUNT_SEQ_MONITOR_WRAP_SAT_EN makes wrap_count saturate instead of rolling over.
module count_seq_monitor
   import count_seq_monitor_pkg::*;
#(
   parameter int unsigned LOCK_LEN = 4,
   parameter int unsigned WRAP_W   = 8,
   parameter int unsigned ERR_W    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        q_in,
   input  logic              valid_in,
   input  logic              err_clr,
   output logic              locked,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              err_pulse,
   output logic              err_sticky,
   output logic [ERR_W-1:0]  err_count
);

   state_e     state_q, state_d;
   logic [1:0] exp_q, exp_d;
   logic [3:0] run_q, run_d;
   logic       locked_q, locked_d;
   logic       wrap_pulse_q, wrap_pulse_d;
   logic       err_pulse_q, err_pulse_d;
   logic       err_sticky_q, err_sticky_d;
   logic       wrap_ev, err_ev;

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      run_d   = run_q;
      wrap_ev = 1'b0;
      err_ev  = 1'b0;
      if (valid_in) begin
         exp_d = next_val(q_in);
         case (state_q)
            ST_IDLE: begin
               run_d   = 4'd1;
               state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
               if (q_in == exp_q) begin
                  run_d = run_q + 4'd1;
                  if ((run_q + 4'd1) == 4'(LOCK_LEN)) state_d = ST_TRACK;
               end else begin
                  run_d = 4'd1;
               end
            end
            ST_TRACK: begin
               if (q_in == exp_q) begin
                  wrap_ev = (q_in == SEQ_FIRST);
               end else begin
                  err_ev  = 1'b1;
                  run_d   = 4'd1;
                  state_d = ST_ACQUIRE;
               end
            end
            default: begin
               run_d   = 4'd0;
               state_d = ST_IDLE;
            end
         endcase
      end
      locked_d     = (state_d == ST_TRACK);
      wrap_pulse_d = wrap_ev;
      err_pulse_d  = err_ev;
      err_sticky_d = err_ev ? 1'b1 : (err_clr ? 1'b0 : err_sticky_q);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         exp_q        <= '0;
         run_q        <= '0;
         locked_q     <= 1'b0;
         wrap_pulse_q <= 1'b0;
         err_pulse_q  <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         run_q        <= run_d;
         locked_q     <= locked_d;
         wrap_pulse_q <= wrap_pulse_d;
         err_pulse_q  <= err_pulse_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err_ev),
      .clr   (err_clr),
      .cnt   (err_count)
   );

`ifdef COUNT_SEQ_MONITOR_WRAP_SAT_EN
   sat_counter #(.W(WRAP_W)) u_wrap_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (wrap_ev),
      .clr   (1'b0),
      .cnt   (wrap_count)
   );
`else
   logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

   always_comb begin
      wrap_cnt_d = wrap_cnt_q;
      if (wrap_ev) wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wrap_cnt_q <= '0;
      end else begin
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign wrap_count = wrap_cnt_q;
`endif

   assign locked     = locked_q;
   assign wrap_pulse = wrap_pulse_q;
   assign err_pulse  = err_pulse_q;
   assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed self-checking bench for count_seq_monitor (default and WRAP_W=2 instances).
module tb_count_seq_monitor;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] q_in = 2'd0;
   logic       valid_in = 1'b0;
   logic       err_clr = 1'b0;

   logic       locked, wrap_pulse, err_pulse, err_sticky;
   logic [7:0] wrap_count;
   logic [3:0] err_count;

   logic       locked2, wrap_pulse2, err_pulse2, err_sticky2;
   logic [1:0] wrap_count2;
   logic [3:0] err_count2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   count_seq_monitor #(.LOCK_LEN(4), .WRAP_W(8), .ERR_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .q_in       (q_in),
      .valid_in   (valid_in),
      .err_clr    (err_clr),
      .locked     (locked),
      .wrap_pulse (wrap_pulse),
      .wrap_count (wrap_count),
      .err_pulse  (err_pulse),
      .err_sticky (err_sticky),
      .err_count  (err_count)
   );

   count_seq_monitor #(.LOCK_LEN(4), .WRAP_W(2), .ERR_W(4)) dut2 (
      .clk        (clk),
      .reset      (reset),
      .q_in       (q_in),
      .valid_in   (valid_in),
      .err_clr    (err_clr),
      .locked     (locked2),
      .wrap_pulse (wrap_pulse2),
      .wrap_count (wrap_count2),
      .err_pulse  (err_pulse2),
      .err_sticky (err_sticky2),
      .err_count  (err_count2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic lk, input logic wp, input int wc,
                       input logic ep, input logic es, input int ec);
      chk({tag, ".locked"},     32'(locked),     32'(lk));
      chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(wp));
      chk({tag, ".wrap_count"}, 32'(wrap_count), 32'(wc));
      chk({tag, ".err_pulse"},  32'(err_pulse),  32'(ep));
      chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(es));
      chk({tag, ".err_count"},  32'(err_count),  32'(ec));
   endtask

   task automatic step(input logic v, input logic [1:0] q, input logic clr);
      @(negedge clk);
      reset    = 1'b1;
      valid_in = v;
      q_in     = q;
      err_clr  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b0;
      valid_in = 1'b1;
      q_in     = 2'd1;
      err_clr  = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      bad++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [1:0] e, m;
      logic [1:0] seq5 [5];
      int exp_w2;

      do_reset();
      do_reset();
      outs("reset", 0, 0, 0, 0, 0, 0);
      chk("reset.wrap_count2", 32'(wrap_count2), 32'd0);

      // lock on free-running counter
      step(1, 2'd0, 0); outs("s0", 0, 0, 0, 0, 0, 0);
      step(1, 2'd1, 0);
      step(1, 2'd2, 0); chk("s2.locked", 32'(locked), 32'd0);
      step(1, 2'd3, 0); outs("lock", 1, 0, 0, 0, 0, 0);
      step(1, 2'd0, 0); outs("wrap1", 1, 1, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step(1, 2'd1, 0); chk("mid.wrap_pulse", 32'(wrap_pulse), 32'd0);
         step(1, 2'd2, 0);
         step(1, 2'd3, 0);
         step(1, 2'd0, 0); chk("wrapk.wrap_count", 32'(wrap_count), 32'(k + 2));
      end
      chk("wrap4.wrap_pulse", 32'(wrap_pulse), 32'd1);

      // mismatch while tracking, then relock without counting a wrap in ACQUIRE
      step(1, 2'd2, 0); outs("err", 0, 0, 4, 1, 1, 1);
      step(1, 2'd3, 0); outs("acq1", 0, 0, 4, 0, 1, 1);
      step(1, 2'd0, 0); outs("acq_nowrap", 0, 0, 4, 0, 1, 1);
      step(1, 2'd1, 0); outs("relock", 1, 0, 4, 0, 1, 1);

      // 20 forced mismatches: err_count saturates at 15
      e = 2'd2;
      for (int i = 0; i < 20; i++) begin
         m = e + 2'd2;
         step(1, m, 0);
         chk("sat.err_pulse", 32'(err_pulse), 32'd1);
         chk("sat.locked_lo", 32'(locked), 32'd0);
         step(1, m + 2'd1, 0);
         step(1, m + 2'd2, 0);
         step(1, m + 2'd3, 0);
         chk("sat.locked_hi", 32'(locked), 32'd1);
         e = m;
      end
      outs("sat", 1, 0, 4, 0, 1, 15);
      step(0, 2'd3, 1); outs("clr", 1, 0, 4, 0, 0, 0);

      // clear and error in the same cycle: error wins
      m = e + 2'd2;
      step(1, m, 1); outs("clr_err", 0, 0, 4, 1, 1, 1);
      step(1, m + 2'd1, 0);
      step(1, m + 2'd2, 0);
      step(1, m + 2'd3, 0); outs("clr_relock", 1, 0, 4, 0, 1, 1);

      // valid toggling: same timing in valid-cycle units, no pulses when idle
      do_reset();
      outs("reset2", 0, 0, 0, 0, 0, 0);
      seq5[0] = 2'd0; seq5[1] = 2'd1; seq5[2] = 2'd2; seq5[3] = 2'd3; seq5[4] = 2'd0;
      for (int i = 0; i < 5; i++) begin
         step(1, seq5[i], 0);
         chk("tog.locked", 32'(locked), 32'(i >= 3));
         chk("tog.wrap_pulse", 32'(wrap_pulse), 32'(i == 4));
         step(0, 2'd2, 0);
         chk("idle.locked", 32'(locked), 32'(i >= 3));
         chk("idle.wrap_pulse", 32'(wrap_pulse), 32'd0);
         chk("idle.err_pulse", 32'(err_pulse), 32'd0);
         chk("idle.wrap_count", 32'(wrap_count), 32'(i == 4));
      end

      // reach five wraps, then reset mid-operation
      for (int k = 0; k < 4; k++) begin
         step(1, 2'd1, 0);
         step(1, 2'd2, 0);
         step(1, 2'd3, 0);
         step(1, 2'd0, 0);
      end
      outs("five", 1, 1, 5, 0, 0, 0);
`ifdef COUNT_SEQ_MONITOR_WRAP_SAT_EN
      exp_w2 = 3;
`else
      exp_w2 = 1;
`endif
      chk("five.wrap_count2", 32'(wrap_count2), 32'(exp_w2));
      do_reset();
      outs("reset3", 0, 0, 0, 0, 0, 0);
      chk("reset3.wrap_count2", 32'(wrap_count2), 32'd0);
      step(1, 2'd1, 0);
      step(1, 2'd2, 0);
      step(1, 2'd3, 0); chk("idle_again.locked", 32'(locked), 32'd0);
      step(1, 2'd0, 0); outs("idle_again", 1, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
